// File: rtl/ray_batch_ctrl.sv
// ray_batch_ctrl: sequences one ray at a time through a triangle intersector and returns the closest-hit result.
// Define RAY_BATCH_STATS_EN to enable the ray/hit statistics counters; otherwise they are tied to 0.
module ray_batch_ctrl #(
  parameter logic signed [31:0] T_MISS = 32'sh7fffffff
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_ray_valid,
  output logic               o_ray_ready,
  input  logic [191:0]       i_ray,
  input  logic [31:0]        i_ray_id,
  input  logic [31:0]        i_baseaddr,
  input  logic [31:0]        i_tri_cnt,
  output logic               o_ins_start,
  output logic [31:0]        o_ins_baseaddr,
  output logic [191:0]       o_ins_ray,
  output logic [31:0]        o_ins_tri_cnt,
  input  logic               i_ins_hit,
  input  logic signed [31:0] i_ins_t,
  input  logic [31:0]        i_ins_tri_index,
  input  logic               i_ins_finish,
  output logic               o_res_valid,
  output logic [31:0]        o_res_id,
  output logic               o_res_hit,
  output logic signed [31:0] o_res_t,
  output logic [31:0]        o_res_tri_index,
  input  logic               i_res_ready,
  output logic [31:0]        o_ray_cnt,
  output logic [31:0]        o_hit_cnt
);
  typedef enum logic [2:0] {IDLE, START, ARM, WAIT, OUT} state_t;
  state_t state_q, state_d;
  logic [191:0] ray_q, ray_d;
  logic [31:0] id_q, id_d, base_q, base_d, cnt_q, cnt_d, idx_q, idx_d;
  logic signed [31:0] t_q, t_d;
  logic start_q, start_d, vld_q, vld_d, hit_q, hit_d;
  logic accept, done;
  assign accept = i_ray_valid && (state_q == IDLE);
  assign done = (state_q == OUT) && i_res_ready;
  always_comb begin
    state_d = state_q;
    ray_d = ray_q;
    id_d = id_q;
    base_d = base_q;
    cnt_d = cnt_q;
    start_d = 1'b0;
    vld_d = vld_q;
    hit_d = hit_q;
    t_d = t_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (i_ray_valid) begin
        ray_d = i_ray;
        id_d = i_ray_id;
        base_d = i_baseaddr;
        cnt_d = i_tri_cnt;
        state_d = (i_tri_cnt != 32'd0) ? START : OUT;
        start_d = (i_tri_cnt != 32'd0);
        vld_d = (i_tri_cnt == 32'd0);
        hit_d = 1'b0;
        t_d = T_MISS;
        idx_d = 32'd0;
      end
      START: state_d = ARM;
      ARM: state_d = WAIT;
      WAIT: if (i_ins_finish) begin
        state_d = OUT;
        vld_d = 1'b1;
        hit_d = i_ins_hit;
        t_d = i_ins_hit ? i_ins_t : T_MISS;
        idx_d = i_ins_hit ? i_ins_tri_index : 32'd0;
      end
      OUT: if (i_res_ready) begin
        state_d = IDLE;
        vld_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      ray_q <= '0;
      id_q <= '0;
      base_q <= '0;
      cnt_q <= '0;
      start_q <= 1'b0;
      vld_q <= 1'b0;
      hit_q <= 1'b0;
      t_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      ray_q <= ray_d;
      id_q <= id_d;
      base_q <= base_d;
      cnt_q <= cnt_d;
      start_q <= start_d;
      vld_q <= vld_d;
      hit_q <= hit_d;
      t_q <= t_d;
      idx_q <= idx_d;
    end
  end
  assign o_ray_ready = (state_q == IDLE);
  assign o_ins_start = start_q;
  assign o_ins_baseaddr = base_q;
  assign o_ins_ray = ray_q;
  assign o_ins_tri_cnt = cnt_q;
  assign o_res_valid = vld_q;
  assign o_res_id = id_q;
  assign o_res_hit = hit_q;
  assign o_res_t = t_q;
  assign o_res_tri_index = idx_q;
`ifdef RAY_BATCH_STATS_EN
  logic [31:0] ray_cnt_q, ray_cnt_d, hit_cnt_q, hit_cnt_d;
  always_comb begin
    ray_cnt_d = ray_cnt_q + {31'd0, done};
    hit_cnt_d = hit_cnt_q + {31'd0, done && hit_q};
  end
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ray_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      ray_cnt_q <= ray_cnt_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end
  assign o_ray_cnt = ray_cnt_q;
  assign o_hit_cnt = hit_cnt_q;
`else
  logic unused_done;
  assign unused_done = done;
  assign o_ray_cnt = 32'd0;
  assign o_hit_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_ray_batch_ctrl.sv
// tb_ray_batch_ctrl: directed bench for ray_batch_ctrl with a hand-driven intersector stub.
module tb_ray_batch_ctrl;
  logic clk = 1'b0;
  logic rstn, ray_valid, ray_ready, ins_start, ins_hit, ins_finish;
  logic res_valid, res_hit, res_ready;
  logic [191:0] ray, ins_ray;
  logic [31:0] ray_id, baseaddr, tri_cnt, ins_baseaddr, ins_tri_cnt, ins_tri_index;
  logic [31:0] res_id, res_tri_index, ray_cnt, hit_cnt;
  logic signed [31:0] ins_t, res_t;
  int n_chk = 0, n_fail = 0, starts = 0, s0;
  logic [31:0] t_hold;

  always #5 clk = ~clk;
  always @(negedge clk) if (ins_start) starts++;

  ray_batch_ctrl dut (
    .i_clk(clk), .i_rstn(rstn), .i_ray_valid(ray_valid), .o_ray_ready(ray_ready),
    .i_ray(ray), .i_ray_id(ray_id), .i_baseaddr(baseaddr), .i_tri_cnt(tri_cnt),
    .o_ins_start(ins_start), .o_ins_baseaddr(ins_baseaddr), .o_ins_ray(ins_ray),
    .o_ins_tri_cnt(ins_tri_cnt), .i_ins_hit(ins_hit), .i_ins_t(ins_t),
    .i_ins_tri_index(ins_tri_index), .i_ins_finish(ins_finish),
    .o_res_valid(res_valid), .o_res_id(res_id), .o_res_hit(res_hit), .o_res_t(res_t),
    .o_res_tri_index(res_tri_index), .i_res_ready(res_ready),
    .o_ray_cnt(ray_cnt), .o_hit_cnt(hit_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [31:0] id, input logic [31:0] cnt);
    ray_id = id;
    tri_cnt = cnt;
    baseaddr = 32'h1000 + id;
    ray = {32'h1, 32'h2, id, 32'h00010000, 32'h00020000, 32'h00030000};
    ray_valid = 1'b1;
    tick();
    ray_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!res_valid && k < 100) begin
      tick();
      k++;
    end
    chk("valid_timeout", res_valid, 1'b1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("hs_valid_low", res_valid, 1'b0);
    chk("hs_ready_high", ray_ready, 1'b1);
  endtask

  task automatic run_ray(input logic [31:0] id, input logic hit, input logic [31:0] t, input logic [31:0] idx);
    accept(id, 32'd4);
    ins_finish = 1'b0;
    tick();
    tick();
    ins_hit = hit;
    ins_t = t;
    ins_tri_index = idx;
    ins_finish = 1'b1;
    wait_valid();
    chk("run_hit", res_hit, hit);
    chk("run_id", res_id, id);
    handshake();
  endtask

  initial begin
    rstn = 1'b0; ray_valid = 1'b0; res_ready = 1'b0; ray = '0; ray_id = '0;
    baseaddr = '0; tri_cnt = '0; ins_hit = 1'b0; ins_t = '0; ins_tri_index = '0;
    ins_finish = 1'b1;
    tick();
    tick();
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_start", ins_start, 1'b0);
    chk("rst_t", res_t, 32'd0);
    chk("rst_cnt", ins_tri_cnt, 32'd0);
    chk("rst_raycnt", ray_cnt, 32'd0);
    rstn = 1'b1;
    tick();
    chk("rst_ready", ray_ready, 1'b1);
    // hit: intersector finishes 20 cycles after start
    s0 = starts;
    accept(32'h11, 32'd5);
    ins_finish = 1'b0;
    chk("hit_start", ins_start, 1'b1);
    chk("hit_ready_low", ray_ready, 1'b0);
    chk("hit_ins_ray", ins_ray, {32'h1, 32'h2, 32'h11, 32'h00010000, 32'h00020000, 32'h00030000});
    chk("hit_ins_base", ins_baseaddr, 32'h1011);
    chk("hit_ins_cnt", ins_tri_cnt, 32'd5);
    tick();
    chk("hit_start_1cyc", ins_start, 1'b0);
    for (int i = 0; i < 19; i++) tick();
    chk("hit_no_early", res_valid, 1'b0);
    ins_hit = 1'b1; ins_t = 32'h00018000; ins_tri_index = 32'd3; ins_finish = 1'b1;
    wait_valid();
    chk("hit_hit", res_hit, 1'b1);
    chk("hit_t", res_t, 32'h00018000);
    chk("hit_idx", res_tri_index, 32'd3);
    chk("hit_id", res_id, 32'h11);
    chk("hit_one_start", starts - s0, 1);
    chk("hit_hold_ray", ins_ray, {32'h1, 32'h2, 32'h11, 32'h00010000, 32'h00020000, 32'h00030000});
    handshake();
    // miss
    accept(32'h22, 32'd9);
    ins_finish = 1'b0;
    tick(); tick(); tick();
    ins_hit = 1'b0; ins_t = 32'h00005000; ins_tri_index = 32'd7; ins_finish = 1'b1;
    wait_valid();
    chk("miss_hit", res_hit, 1'b0);
    chk("miss_t", res_t, 32'h7fffffff);
    chk("miss_idx", res_tri_index, 32'd0);
    chk("miss_id", res_id, 32'h22);
    handshake();
    // zero count with backpressure
    s0 = starts;
    accept(32'h33, 32'd0);
    chk("zero_valid", res_valid, 1'b1);
    chk("zero_hit", res_hit, 1'b0);
    chk("zero_t", res_t, 32'h7fffffff);
    chk("zero_idx", res_tri_index, 32'd0);
    chk("zero_id", res_id, 32'h33);
    t_hold = res_t;
    ray_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_t", res_t, t_hold);
      chk("bp_id", res_id, 32'h33);
      chk("bp_ready_low", ray_ready, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    ray_valid = 1'b0;
    chk("bp_release_valid", res_valid, 1'b0);
    chk("bp_release_ready", ray_ready, 1'b1);
    chk("zero_no_start", starts - s0, 0);
    // stale finish held high from reset
    rstn = 1'b0;
    ins_finish = 1'b1; ins_hit = 1'b1; ins_t = 32'h00020000; ins_tri_index = 32'd2;
    tick();
    rstn = 1'b1;
    tick();
    accept(32'h44, 32'd3);
    chk("stale_start", res_valid, 1'b0);
    tick();
    chk("stale_arm", res_valid, 1'b0);
    tick();
    chk("stale_wait", res_valid, 1'b0);
    tick();
    chk("stale_capture", res_valid, 1'b1);
    chk("stale_t", res_t, 32'h00020000);
    chk("stale_idx", res_tri_index, 32'd2);
    handshake();
    tick(); tick();
    chk("stale_no_double", res_valid, 1'b0);
    // reset while waiting on the intersector
    accept(32'h55, 32'd8);
    ins_finish = 1'b0;
    tick(); tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("abort_valid", res_valid, 1'b0);
    chk("abort_cnt", ins_tri_cnt, 32'd0);
    ins_finish = 1'b1;
    tick();
    chk("abort_ready", ray_ready, 1'b1);
    tick(); tick();
    chk("abort_no_result", res_valid, 1'b0);
    run_ray(32'h61, 1'b1, 32'h00011000, 32'd1);
    run_ray(32'h62, 1'b0, 32'h00012000, 32'd2);
    run_ray(32'h63, 1'b1, 32'h00013000, 32'd3);
`ifdef RAY_BATCH_STATS_EN
    chk("stats_rays", ray_cnt, 32'd3);
    chk("stats_hits", hit_cnt, 32'd2);
`else
    chk("stats_rays_off", ray_cnt, 32'd0);
    chk("stats_hits_off", hit_cnt, 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
